// File: rtl/mod_exp_sqm.sv
// rtl/mod_exp_sqm.sv - square-and-multiply modular exponentiator (MOD_EXP_CONST_TIME_EN: fixed-latency variant)
module mod_exp_sqm #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result
);

    localparam int XW = WIDTH + 2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MUL, SQR, CHECK, FIN} state_t;

    state_t               state, nxt;
    logic [WIDTH-1:0]     b_reg, m_reg, acc;
    logic [EXP_WIDTH-1:0] e_reg;
    logic [XW-1:0]        p;
    logic [CW-1:0]        cnt;
    logic                 cnt_last;
    logic                 op_fault;

`ifdef MOD_EXP_CONST_TIME_EN
    localparam int EW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [EW-1:0] BIT_LAST = EW'(EXP_WIDTH - 1);
    logic [EW-1:0]        bcnt;
    logic [WIDTH-1:0]     scratch;
`endif

    assign op_fault = (m_reg == '0) || (b_reg >= m_reg);
    assign cnt_last = (cnt == CNT_LAST);

    // The CHECK decision: which step, if any, the next exponent bit needs.
    function automatic state_t check_dec(input logic [EXP_WIDTH-1:0] e);
        if (e == '0)
            return FIN;
        else if (e[0])
            return MUL;
        else
            return SQR;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start) nxt = LOAD;
`ifdef MOD_EXP_CONST_TIME_EN
            LOAD:  nxt = MUL;
            MUL:   if (cnt_last) nxt = SQR;
            SQR:   if (cnt_last) nxt = (bcnt == BIT_LAST) ? FIN : MUL;
            CHECK: nxt = MUL;
`else
            LOAD:  nxt = op_fault ? FIN : check_dec(e_reg);
            MUL:   if (cnt_last) nxt = SQR;
            SQR:   if (cnt_last) nxt = check_dec(e_reg >> 1);
            CHECK: nxt = check_dec(e_reg);
`endif
            FIN:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Interleaved multiplier: one bit of y (always B) per cycle, MSB first.
    logic [WIDTH-1:0] x_sel;
    logic             y_bit;
    logic [XW-1:0]    m_x, p_cur, t_dbl, t_red, t_add, p_next;

    always_comb begin
        x_sel  = (state == MUL) ? acc : b_reg;
        y_bit  = b_reg[CNT_LAST - cnt];
        m_x    = XW'(m_reg);
        p_cur  = (cnt == '0) ? '0 : p;
        t_dbl  = p_cur << 1;
        t_red  = (t_dbl >= m_x) ? (t_dbl - m_x) : t_dbl;
        t_add  = y_bit ? (t_red + XW'(x_sel)) : t_red;
        p_next = (t_add >= m_x) ? (t_add - m_x) : t_add;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_reg   <= '0;
            m_reg   <= '0;
            e_reg   <= '0;
            acc     <= '0;
            p       <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            result  <= '0;
`ifdef MOD_EXP_CONST_TIME_EN
            bcnt    <= '0;
            scratch <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        b_reg <= base;
                        e_reg <= exponent;
                        m_reg <= modulus;
                        acc   <= WIDTH'(1);
                        busy  <= 1'b1;
                        error <= 1'b0;
                        cnt   <= '0;
`ifdef MOD_EXP_CONST_TIME_EN
                        bcnt  <= '0;
`endif
                    end
                end
                LOAD: begin
                    cnt <= '0;
                    if (op_fault) begin
                        error <= 1'b1;
                        acc   <= '0;
                    end else if (m_reg == WIDTH'(1)) begin
                        acc   <= '0;
                    end
                end
                MUL: begin
                    p   <= p_next;
                    cnt <= cnt_last ? '0 : cnt + CW'(1);
                    if (cnt_last) begin
`ifdef MOD_EXP_CONST_TIME_EN
                        // Dummy multiply keeps timing independent of the key bit.
                        if (e_reg[0] && !error)
                            acc <= p_next[WIDTH-1:0];
                        else
                            scratch <= p_next[WIDTH-1:0];
`else
                        acc <= p_next[WIDTH-1:0];
`endif
                    end
                end
                SQR: begin
                    p   <= p_next;
                    cnt <= cnt_last ? '0 : cnt + CW'(1);
                    if (cnt_last) begin
                        b_reg <= p_next[WIDTH-1:0];
                        e_reg <= e_reg >> 1;
`ifdef MOD_EXP_CONST_TIME_EN
                        bcnt  <= bcnt + EW'(1);
`endif
                    end
                end
                FIN: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_sqm.sv
// tb/tb_mod_exp_sqm.sv - randomized self-checking bench for mod_exp_sqm
module tb_mod_exp_sqm;

    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [31:0] exponent = '0;
    logic [31:0] modulus = '0;
    logic        busy, done, error;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    mod_exp_sqm #(.WIDTH(32), .EXP_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_fault(input logic [31:0] b, input logic [31:0] m);
        return (m == 0) || (b >= m);
    endfunction

    function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e,
                                            input logic [31:0] m);
        longint unsigned r, bb, mm;
        logic [31:0] ee;
        if (ref_fault(b, m)) return 32'd0;
        mm = 64'(m);
        r  = 64'd1 % mm;
        bb = 64'(b);
        ee = e;
        while (ee != 0) begin
            if (ee[0]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
            ee = ee >> 1;
        end
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] b, input logic [31:0] e,
                                   input logic [31:0] m);
`ifdef MOD_EXP_CONST_TIME_EN
        return 2 + 2 * 32 * 32;
`else
        int pc, bl;
        if (ref_fault(b, m)) return 2;
        pc = 0;
        bl = 0;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) begin
                pc++;
                bl = i + 1;
            end
        end
        return 2 + 32 * (pc + bl);
`endif
    endfunction

    task automatic run_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                          input bit repulse, input string tag);
        int n;
        int extra;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base = $urandom; exponent = $urandom; modulus = $urandom;
        busy_ok = (busy === 1'b1);
        n = 0;
        seen = 0;
        while (!seen && n < LIMIT) begin
            @(posedge clk);
            n++;
            #1;
            if (done === 1'b1) begin
                seen = 1;
                if (busy !== 1'b0) busy_ok = 0;
            end else if (busy !== 1'b1) begin
                busy_ok = 0;
            end
            start = (repulse && n == 10 && !seen);
        end
        start = 1'b0;
        check({tag, "_done"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'(ref_lat(b, e, m)));
        check({tag, "_res"}, 64'(result), 64'(ref_pow(b, e, m)));
        check({tag, "_err"}, 64'(error), 64'(ref_fault(b, m)));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        if (repulse) begin
            extra = 0;
            repeat (30) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) extra++;
            end
            check({tag, "_single_done"}, 64'(extra), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] rb, re, rm;
        #1 rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(error), 64'd0);
        check("rst_res", 64'(result), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(32'd5, 32'd3, 32'd23, 0, "p5e3");
        run_op(32'd5, 32'd6, 32'd23, 0, "dh_a");
        run_op(32'd5, 32'd15, 32'd23, 0, "dh_b");
        run_op(32'd19, 32'd6, 32'd23, 0, "dh_ka");
        run_op(32'd8, 32'd15, 32'd23, 0, "dh_kb");
        run_op(32'd7, 32'd0, 32'd13, 0, "e0");
        run_op(32'd0, 32'd5, 32'd1, 0, "m1");
        run_op(32'd4, 32'd5, 32'd0, 0, "m0");
        run_op(32'd30, 32'd5, 32'd23, 0, "bgem");
        run_op(32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 1, "full");

        for (int i = 0; i < 14; i++) begin
            rm = (i % 4 == 0) ? 32'($urandom_range(2, 50)) : $urandom;
            if (rm == 0) rm = 32'd97;
            rb = $urandom % rm;
            re = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            run_op(rb, re, rm, 0, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        base = 32'd5; exponent = 32'd3; modulus = 32'd23; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_err", 64'(error), 64'd0);
        check("arst_res", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd3, 32'd4, 32'd7, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
